data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_pkg.sv | 48 ++++
 rtl/data_mem_ctrl_if.sv | 22 ++
 rtl/byte_lane_sel.sv | 21 ++
 rtl/data_mem_ctrl.sv | 117 +++++++++++
 tb/tb_data_mem_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller:
// access-size encodings, FSM state type, byte count and address alignment.
package data_mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 2;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Reserved size behaves as a word access.
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_HALF: byte_count = 3'd2;
         SIZE_BYTE: byte_count = 3'd1;
         default:   byte_count = 3'd4;
      endcase
   endfunction

   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0] size);
      case (size)
         SIZE_HALF: align_addr = {a[ADDR_W-1:1], 1'b0};
         SIZE_BYTE: align_addr = a;
         default:   align_addr = {a[ADDR_W-1:2], 2'b00};
      endcase
   endfunction

   // Bits of rdata that survive load capture; the rest are zeroed.
   function automatic logic [DATA_W-1:0] load_keep_mask(input logic [1:0] size);
      case (size)
         SIZE_HALF: load_keep_mask = 32'h0000_FFFF;
         SIZE_BYTE: load_keep_mask = 32'h0000_00FF;
         default:   load_keep_mask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Byte-wide memory bus between the controller (master) and memory (slave).
interface data_mem_ctrl_if;
   import data_mem_pkg::*;

   logic                  bus_req;
   logic                  bus_we;
   logic [ADDR_W-1:0]     bus_addr;
   logic [BYTE_W-1:0]     bus_wdata;
   logic [BYTE_W-1:0]     bus_rdata;
   logic                  bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/byte_lane_sel.sv
// Little-endian lane steering: picks the store byte for the current beat and
// inserts the returned load byte into the assembled load word.
module byte_lane_sel
   import data_mem_pkg::*;
(
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [CNT_W-1:0]  i_cnt,
   input  logic [BYTE_W-1:0] i_bus_rdata,
   output logic [BYTE_W-1:0] o_store_byte,
   output logic [DATA_W-1:0] o_rdata_ins
);

   logic [4:0] w_shamt;

   assign w_shamt      = {i_cnt, 3'b000};
   assign o_store_byte = BYTE_W'(i_wdata >> w_shamt);
   assign o_rdata_ins  = (i_rdata & ~(32'h0000_00FF << w_shamt))
                       | (DATA_W'(i_bus_rdata) << w_shamt);

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: serialises word/halfword/byte accesses
// onto a byte-wide bus and stalls the pipeline until the access completes.
module data_mem_ctrl
   import data_mem_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_enable,
   input  logic               mem_RW,
   input  logic [1:0]         mem_size,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic               stall,
   data_mem_ctrl_if.master    bus
);

   state_t              r_state,  w_state_nxt;
   logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
   logic [CNT_W-1:0]    r_last,   w_last_nxt;
   logic [ADDR_W-1:0]   r_base,   w_base_nxt;
   logic [DATA_W-1:0]   r_wdata,  w_wdata_nxt;
   logic                r_we,     w_we_nxt;
   logic [DATA_W-1:0]   r_rdata,  w_rdata_nxt;

   logic [BYTE_W-1:0]   w_store_byte;
   logic [DATA_W-1:0]   w_rdata_ins;

   byte_lane_sel u_lane (
      .i_wdata      (r_wdata),
      .i_rdata      (r_rdata),
      .i_cnt        (r_cnt),
      .i_bus_rdata  (bus.bus_rdata),
      .o_store_byte (w_store_byte),
      .o_rdata_ins  (w_rdata_ins)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= '0;
         r_base  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_base  <= w_base_nxt;
         r_wdata <= w_wdata_nxt;
         r_we    <= w_we_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

   // Bus outputs are decoded from registered state only; ack outside BUSY is ignored.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_last_nxt    = r_last;
      w_base_nxt    = r_base;
      w_wdata_nxt   = r_wdata;
      w_we_nxt      = r_we;
      w_rdata_nxt   = r_rdata;
      stall         = 1'b0;
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_wdata = '0;

      case (r_state)
         IDLE: begin
            if (mem_enable) begin
               stall       = 1'b1;
               w_state_nxt = BUSY;
               w_cnt_nxt   = '0;
               w_last_nxt  = CNT_W'(byte_count(mem_size) - 3'd1);
               w_base_nxt  = align_addr(addr, mem_size);
               w_wdata_nxt = wdata;
               w_we_nxt    = mem_RW;
               if (!mem_RW) begin
                  w_rdata_nxt = r_rdata & load_keep_mask(mem_size);
               end
            end
         end
         BUSY: begin
            stall         = 1'b1;
            bus.bus_req   = 1'b1;
            bus.bus_we    = r_we;
            bus.bus_addr  = r_base + ADDR_W'(r_cnt);
            bus.bus_wdata = w_store_byte;
            if (bus.bus_ack) begin
               if (!r_we) begin
                  w_rdata_nxt = w_rdata_ins;
               end
               if (r_cnt == r_last) begin
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt = r_cnt + 2'd1;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: a byte-bus responder scoreboards every
// bus beat against expectations queued by each scenario task.
module tb_data_mem_ctrl;

   logic        clk;
   logic        reset;
   logic        mem_enable;
   logic        mem_RW;
   logic [1:0]  mem_size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;

   data_mem_ctrl_if bus_if ();

   data_mem_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .mem_enable (mem_enable),
      .mem_RW     (mem_RW),
      .mem_size   (mem_size),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .bus        (bus_if)
   );

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [7:0]  wb;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mem [logic [31:0]];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   bit          stray_ack = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Responder: acks only expected beats, checks each beat (and its stability while waiting).
   always @(negedge clk) begin
      if (bus_if.bus_req) begin
         if (exp_q.size() == 0) begin
            bus_if.bus_ack = 1'b0;
         end else begin
            checks++;
            if (bus_if.bus_addr !== exp_q[0].a || bus_if.bus_we !== exp_q[0].we ||
                (exp_q[0].we && bus_if.bus_wdata !== exp_q[0].wb)) begin
               errors++;
               $display("FAIL bus_beat got addr=%h we=%b wdata=%h exp addr=%h we=%b wdata=%h",
                        bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata,
                        exp_q[0].a, exp_q[0].we, exp_q[0].wb);
            end
            if (wait_cnt >= ack_delay) begin
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_rdata = mem.exists(bus_if.bus_addr) ? mem[bus_if.bus_addr] : 8'h00;
               void'(exp_q.pop_front());
               wait_cnt = 0;
            end else begin
               bus_if.bus_ack = 1'b0;
               wait_cnt++;
            end
         end
      end else begin
         bus_if.bus_ack = stray_ack;
         wait_cnt = 0;
      end
   end

   task automatic push_exp(input logic we, input logic [31:0] a, input logic [7:0] wb);
      exp_t e;
      e.we = we; e.a = a; e.wb = wb;
      exp_q.push_back(e);
   endtask

   // Drives one access from an IDLE cycle; returns after the cycle following DONE.
   task automatic run_access(input logic rw, input logic [1:0] size, input logic [31:0] a,
                             input logic [31:0] wd, input bit keep_en,
                             output int stall_cyc, output logic [31:0] rd,
                             output int t_start, output int t_done, output bit to);
      mem_enable = 1'b1; mem_RW = rw; mem_size = size; addr = a; wdata = wd;
      t_start = cyc; t_done = 0; stall_cyc = 0; to = 1'b1; rd = '0;
      @(negedge clk);
      if (stall) stall_cyc++;
      @(posedge clk); #1;
      mem_enable = keep_en;
      addr = $urandom; wdata = $urandom;
      mem_RW = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 3));
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!stall) begin
            to = 1'b0; t_done = cyc; rd = rdata;
            break;
         end
         stall_cyc++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; mem_enable = 1'b0; mem_RW = 1'b0; mem_size = 2'b00;
      addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (rdata !== 32'h0 || stall !== 1'b0 || bus_if.bus_req !== 1'b0 ||
          bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 32'h0 || bus_if.bus_wdata !== 8'h0) begin
         errors++;
         $display("FAIL reset_state got rdata=%h stall=%b req=%b we=%b addr=%h wdata=%h exp all zero",
                  rdata, stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_word_store;
      int sc, ts, td; logic [31:0] rd; bit to;
      push_exp(1, 32'h100, 8'hDD); push_exp(1, 32'h101, 8'hCC);
      push_exp(1, 32'h102, 8'hBB); push_exp(1, 32'h103, 8'hAA);
      run_access(1'b1, 2'b00, 32'h100, 32'hAABBCCDD, 1'b0, sc, rd, ts, td, to);
      checks++;
      if (to !== 1'b0 || sc != 5) begin
         errors++; $display("FAIL word_store_stall got %0d (timeout=%0d) exp 5", sc, to);
      end
      checks++;
      if (td - ts != 5) begin
         errors++; $display("FAIL word_store_latency got %0d exp 5", td - ts);
      end
      checks++;
      if (exp_q.size() != 0 || rd !== 32'h0) begin
         errors++; $display("FAIL word_store_done got pending=%0d rdata=%h exp 0 0", exp_q.size(), rd);
      end
   endtask

   task automatic test_byte_load;
      int sc, ts, td; logic [31:0] rd; bit to;
      mem[32'h203] = 8'h9F;
      push_exp(0, 32'h203, 8'h00);
      run_access(1'b0, 2'b10, 32'h203, 32'hFFFF_FFFF, 1'b0, sc, rd, ts, td, to);
      checks++;
      if (to !== 1'b0 || rd !== 32'h0000_009F) begin
         errors++; $display("FAIL byte_load_rdata got %h exp 0000009f", rd);
      end
      checks++;
      if (sc != 2 || exp_q.size() != 0) begin
         errors++; $display("FAIL byte_load_stall got %0d pending=%0d exp 2 0", sc, exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      int sc1, sc2, ts1, td1, ts2, td2; logic [31:0] rd1, rd2; bit to1, to2;
      mem[32'h600] = 8'hEF; mem[32'h601] = 8'hBE; mem[32'h602] = 8'hAD; mem[32'h603] = 8'hDE;
      push_exp(0, 32'h600, 8'h00); push_exp(0, 32'h601, 8'h00);
      push_exp(0, 32'h602, 8'h00); push_exp(0, 32'h603, 8'h00);
      push_exp(1, 32'h611, 8'h5A);
      run_access(1'b0, 2'b00, 32'h600, 32'h0, 1'b1, sc1, rd1, ts1, td1, to1);
      run_access(1'b1, 2'b10, 32'h611, 32'h0000_005A, 1'b0, sc2, rd2, ts2, td2, to2);
      checks++;
      if (to1 !== 1'b0 || rd1 !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL b2b_word_load got %h exp deadbeef", rd1);
      end
      checks++;
      if (to2 !== 1'b0 || ts2 != td1 + 1) begin
         errors++; $display("FAIL b2b_start got cycle %0d exp %0d", ts2, td1 + 1);
      end
      checks++;
      if (sc1 != 5 || sc2 != 2 || exp_q.size() != 0) begin
         errors++; $display("FAIL b2b_stall got %0d,%0d pending=%0d exp 5,2 0", sc1, sc2, exp_q.size());
      end
      checks++;
      if (rd2 !== 32'hDEAD_BEEF || rdata !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL rdata_hold got %h exp deadbeef", rdata);
      end
   endtask

   task automatic test_halfword_wait;
      int sc, ts, td; logic [31:0] rd; bit to;
      mem[32'h304] = 8'h34; mem[32'h305] = 8'h12;
      push_exp(0, 32'h304, 8'h00); push_exp(0, 32'h305, 8'h00);
      ack_delay = 2;
      run_access(1'b0, 2'b01, 32'h305, 32'h0, 1'b0, sc, rd, ts, td, to);
      ack_delay = 0;
      checks++;
      if (to !== 1'b0 || rd !== 32'h0000_1234) begin
         errors++; $display("FAIL half_load_rdata got %h exp 00001234", rd);
      end
      checks++;
      if (sc != 7 || exp_q.size() != 0) begin
         errors++; $display("FAIL half_load_stall got %0d pending=%0d exp 7 0", sc, exp_q.size());
      end
   endtask

   task automatic test_reserved_size;
      int sc, ts, td; logic [31:0] rd; bit to;
      mem[32'h400] = 8'h01; mem[32'h401] = 8'h02; mem[32'h402] = 8'h03; mem[32'h403] = 8'h04;
      for (int i = 0; i < 4; i++) push_exp(0, 32'h400 + 32'(i), 8'h00);
      run_access(1'b0, 2'b11, 32'h402, 32'h0, 1'b0, sc, rd, ts, td, to);
      checks++;
      if (to !== 1'b0 || rd !== 32'h0403_0201 || sc != 5 || exp_q.size() != 0) begin
         errors++; $display("FAIL reserved_size got rdata=%h stall=%0d pending=%0d exp 04030201 5 0",
                            rd, sc, exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      bit hit;
      push_exp(1, 32'h500, 8'h44); push_exp(1, 32'h501, 8'h33);
      mem_enable = 1'b1; mem_RW = 1'b1; mem_size = 2'b00; addr = 32'h500; wdata = 32'h1122_3344;
      @(posedge clk); #1;
      mem_enable = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0) begin hit = 1'b1; break; end
      end
      @(posedge clk); #1;
      checks++;
      if (!hit || bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h502) begin
         errors++; $display("FAIL rst_mid_third got req=%b addr=%h exp 1 00000502", bus_if.bus_req, bus_if.bus_addr);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || bus_if.bus_addr !== 32'h0) begin
         errors++; $display("FAIL rst_mid_idle got req=%b stall=%b rdata=%h addr=%h exp 0 0 0 0",
                            bus_if.bus_req, stall, rdata, bus_if.bus_addr);
      end
      stray_ack = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus_if.bus_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL stray_ack got req=%b stall=%b rdata=%h exp 0 0 0", bus_if.bus_req, stall, rdata);
         end
      end
      stray_ack = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_recovery;
      int sc, ts, td; logic [31:0] rd; bit to;
      mem[32'h700] = 8'hC3;
      push_exp(0, 32'h700, 8'h00);
      run_access(1'b0, 2'b10, 32'h700, 32'h0, 1'b0, sc, rd, ts, td, to);
      checks++;
      if (to !== 1'b0 || rd !== 32'h0000_00C3 || sc != 2 || exp_q.size() != 0) begin
         errors++; $display("FAIL recovery got rdata=%h stall=%0d pending=%0d exp 000000c3 2 0",
                            rd, sc, exp_q.size());
      end
   endtask

   initial begin
      bus_if.bus_ack = 1'b0;
      bus_if.bus_rdata = 8'h00;
      test_reset();
      test_word_store();
      test_byte_load();
      test_back_to_back();
      test_halfword_wait();
      test_reserved_size();
      test_reset_mid();
      test_recovery();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
